// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes and the
// datapath mux/ALU select codes that the ALU decoder and immediate extender also use.
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExecR  = 4'd6,
        StExecI  = 4'd7,
        StAluWb  = 4'd8,
        StBeq    = 4'd9,
        StJal    = 4'd10,
        StTrap   = 4'd11
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle FSM (master) and the datapath (slave).
interface multicycle_control_fsm_if;

    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       illegal_instr;

    modport master (
        input  op, zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
               ImmSrc, RegWrite, illegal_instr
    );

    modport slave (
        output op, zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
               ImmSrc, RegWrite, illegal_instr
    );

endinterface

// File: rtl/multicycle_control_fsm_imm_src_decoder.sv
// Opcode to immediate-format select; purely combinational, unknown opcodes use I-type.
module imm_src_decoder
    import multicycle_control_fsm_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core; memory states stall on mem_ready.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int unsigned STATE_W   = 4,
    parameter bit          TRAP_HALT = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    multicycle_control_fsm_if.master  ctl
);

    logic [STATE_W-1:0] state_q;
    state_e             state;
    state_e             state_d;

    // Low four bits carry the encoding; leftover codes fall through to the default arm.
    assign state = state_e'(state_q[3:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATE_W'(StFetch);
        end else begin
            state_q <= STATE_W'(state_d);
        end
    end

    always_comb begin
        state_d           = StFetch;
        ctl.PCWrite       = 1'b0;
        ctl.AdrSrc        = 1'b0;
        ctl.MemWrite      = 1'b0;
        ctl.IRWrite       = 1'b0;
        ctl.ResultSrc     = RES_ALUOUT;
        ctl.ALUSrcA       = SRCA_PC;
        ctl.ALUSrcB       = SRCB_RS2;
        ctl.ALUOp         = ALUOP_ADD;
        ctl.RegWrite      = 1'b0;
        ctl.illegal_instr = 1'b0;

        case (state)
            StFetch: begin
                ctl.ALUSrcA   = SRCA_PC;
                ctl.ALUSrcB   = SRCB_FOUR;
                ctl.ResultSrc = RES_ALURESULT;
                ctl.IRWrite   = ctl.mem_ready;
                ctl.PCWrite   = ctl.mem_ready;
                state_d       = ctl.mem_ready ? StDecode : StFetch;
            end
            StDecode: begin
                // Precompute the branch target into ALUOut while the opcode is decoded.
                ctl.ALUSrcA = SRCA_OLDPC;
                ctl.ALUSrcB = SRCB_IMM;
                case (ctl.op)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_R:         state_d = StExecR;
                    OP_I:         state_d = StExecI;
                    OP_BEQ:       state_d = StBeq;
                    OP_JAL:       state_d = StJal;
                    default:      state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                ctl.ALUSrcA = SRCA_RS1;
                ctl.ALUSrcB = SRCB_IMM;
                state_d     = ctl.op[5] ? StMemWr : StMemRd;
            end
            StMemRd: begin
                ctl.AdrSrc = 1'b1;
                state_d    = ctl.mem_ready ? StMemWb : StMemRd;
            end
            StMemWb: begin
                ctl.ResultSrc = RES_DATA;
                ctl.RegWrite  = 1'b1;
                state_d       = StFetch;
            end
            StMemWr: begin
                ctl.AdrSrc   = 1'b1;
                ctl.MemWrite = 1'b1;
                state_d      = ctl.mem_ready ? StFetch : StMemWr;
            end
            StExecR: begin
                ctl.ALUSrcA = SRCA_RS1;
                ctl.ALUSrcB = SRCB_RS2;
                ctl.ALUOp   = ALUOP_FUNCT;
                state_d     = StAluWb;
            end
            StExecI: begin
                ctl.ALUSrcA = SRCA_RS1;
                ctl.ALUSrcB = SRCB_IMM;
                ctl.ALUOp   = ALUOP_FUNCT;
                state_d     = StAluWb;
            end
            StAluWb: begin
                ctl.ResultSrc = RES_ALUOUT;
                ctl.RegWrite  = 1'b1;
                state_d       = StFetch;
            end
            StBeq: begin
                ctl.ALUSrcA   = SRCA_RS1;
                ctl.ALUSrcB   = SRCB_RS2;
                ctl.ALUOp     = ALUOP_SUB;
                ctl.ResultSrc = RES_ALUOUT;
                ctl.PCWrite   = ctl.zero;
                state_d       = StFetch;
            end
            StJal: begin
                // Link value PC+4 is formed from OldPC while PC takes the target in ALUOut.
                ctl.ALUSrcA   = SRCA_OLDPC;
                ctl.ALUSrcB   = SRCB_FOUR;
                ctl.ALUOp     = ALUOP_ADD;
                ctl.ResultSrc = RES_ALUOUT;
                ctl.PCWrite   = 1'b1;
                state_d       = StAluWb;
            end
            StTrap: begin
                ctl.illegal_instr = 1'b1;
                state_d           = TRAP_HALT ? StTrap : StFetch;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    imm_src_decoder u_imm_src_decoder (
        .op      (ctl.op),
        .imm_src (ctl.ImmSrc)
    );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench: walks each instruction class cycle by cycle and compares the control word.
module tb_multicycle_control_fsm;

    localparam logic [6:0] L_LW  = 7'b0000011;
    localparam logic [6:0] L_SW  = 7'b0100011;
    localparam logic [6:0] L_R   = 7'b0110011;
    localparam logic [6:0] L_I   = 7'b0010011;
    localparam logic [6:0] L_BEQ = 7'b1100011;
    localparam logic [6:0] L_JAL = 7'b1101111;
    localparam logic [6:0] L_ILL = 7'b1111111;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, RegWrite, illegal}
    localparam logic [13:0] C_F0   = 14'b0000_10_00_10_00_0_0;
    localparam logic [13:0] C_F1   = 14'b1001_10_00_10_00_0_0;
    localparam logic [13:0] C_DEC  = 14'b0000_00_01_01_00_0_0;
    localparam logic [13:0] C_MADR = 14'b0000_00_10_01_00_0_0;
    localparam logic [13:0] C_MRD  = 14'b0100_00_00_00_00_0_0;
    localparam logic [13:0] C_MWB  = 14'b0000_01_00_00_00_1_0;
    localparam logic [13:0] C_MWR  = 14'b0110_00_00_00_00_0_0;
    localparam logic [13:0] C_EXR  = 14'b0000_00_10_00_10_0_0;
    localparam logic [13:0] C_EXI  = 14'b0000_00_10_01_10_0_0;
    localparam logic [13:0] C_AWB  = 14'b0000_00_00_00_00_1_0;
    localparam logic [13:0] C_BEQ1 = 14'b1000_00_10_00_01_0_0;
    localparam logic [13:0] C_BEQ0 = 14'b0000_00_10_00_01_0_0;
    localparam logic [13:0] C_JAL  = 14'b1000_00_01_10_00_0_0;
    localparam logic [13:0] C_TRAP = 14'b0000_00_00_00_00_0_1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    bit         both = 1'b1;
    int         n_vec = 0;
    int         n_err = 0;

    multicycle_control_fsm_if bus_h ();
    multicycle_control_fsm_if bus_c ();

    assign bus_h.op = op;
    assign bus_h.zero = zero;
    assign bus_h.mem_ready = mem_ready;
    assign bus_c.op = op;
    assign bus_c.zero = zero;
    assign bus_c.mem_ready = mem_ready;

    multicycle_control_fsm #(
        .STATE_W   (4),
        .TRAP_HALT (1'b1)
    ) dut_h (
        .clk (clk),
        .rst (rst),
        .ctl (bus_h)
    );

    multicycle_control_fsm #(
        .STATE_W   (4),
        .TRAP_HALT (1'b0)
    ) dut_c (
        .clk (clk),
        .rst (rst),
        .ctl (bus_c)
    );

    logic [13:0] ctrl_h;
    logic [13:0] ctrl_c;

    assign ctrl_h = {bus_h.PCWrite, bus_h.AdrSrc, bus_h.MemWrite, bus_h.IRWrite,
                     bus_h.ResultSrc, bus_h.ALUSrcA, bus_h.ALUSrcB, bus_h.ALUOp,
                     bus_h.RegWrite, bus_h.illegal_instr};
    assign ctrl_c = {bus_c.PCWrite, bus_c.AdrSrc, bus_c.MemWrite, bus_c.IRWrite,
                     bus_c.ResultSrc, bus_c.ALUSrcA, bus_c.ALUSrcB, bus_c.ALUOp,
                     bus_c.RegWrite, bus_c.illegal_instr};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, then compare the state just entered.
    task automatic step(input string tag, input logic [6:0] op_v, input logic z,
                        input logic mr, input logic [13:0] exp);
        @(posedge clk);
        #1;
        op = op_v;
        zero = z;
        mem_ready = mr;
        #1;
        check(tag, 16'(ctrl_h), 16'(exp));
        if (both) check({tag, "_c"}, 16'(ctrl_c), 16'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_h", 16'(ctrl_h), 16'(C_F0));
        check("reset_c", 16'(ctrl_c), 16'(C_F0));

        // add x3,x1,x2 with a one-cycle fetch stall
        step("add_f_stall", L_R, 1'b0, 1'b0, C_F0);
        step("add_fetch",   L_R, 1'b0, 1'b1, C_F1);
        step("add_dec",     L_R, 1'b0, 1'b0, C_DEC);
        check("add_imm_h", 16'(bus_h.ImmSrc), 16'(2'b00));
        check("add_imm_c", 16'(bus_c.ImmSrc), 16'(2'b00));
        step("add_exec",    L_R, 1'b0, 1'b1, C_EXR);
        step("add_wb",      L_R, 1'b0, 1'b1, C_AWB);

        // lw with two wait cycles in MEMRD
        step("lw_fetch", L_LW, 1'b0, 1'b1, C_F1);
        step("lw_dec",   L_LW, 1'b0, 1'b1, C_DEC);
        check("lw_imm", 16'(bus_h.ImmSrc), 16'(2'b00));
        step("lw_adr",   L_LW, 1'b0, 1'b1, C_MADR);
        step("lw_rd_w1", L_LW, 1'b0, 1'b0, C_MRD);
        step("lw_rd_w2", L_LW, 1'b0, 1'b0, C_MRD);
        step("lw_rd",    L_LW, 1'b0, 1'b1, C_MRD);
        step("lw_wb",    L_LW, 1'b0, 1'b1, C_MWB);

        // beq taken then not taken
        step("beqt_fetch", L_BEQ, 1'b1, 1'b1, C_F1);
        step("beqt_dec",   L_BEQ, 1'b1, 1'b1, C_DEC);
        check("beq_imm", 16'(bus_h.ImmSrc), 16'(2'b10));
        step("beqt_beq",   L_BEQ, 1'b1, 1'b1, C_BEQ1);
        step("beqn_fetch", L_BEQ, 1'b0, 1'b1, C_F1);
        step("beqn_dec",   L_BEQ, 1'b0, 1'b1, C_DEC);
        step("beqn_beq",   L_BEQ, 1'b0, 1'b1, C_BEQ0);

        // jal
        step("jal_fetch", L_JAL, 1'b0, 1'b1, C_F1);
        step("jal_dec",   L_JAL, 1'b0, 1'b1, C_DEC);
        check("jal_imm", 16'(bus_h.ImmSrc), 16'(2'b11));
        step("jal_jal",   L_JAL, 1'b0, 1'b1, C_JAL);
        step("jal_wb",    L_JAL, 1'b0, 1'b1, C_AWB);

        // addi
        step("addi_fetch", L_I, 1'b0, 1'b1, C_F1);
        step("addi_dec",   L_I, 1'b0, 1'b1, C_DEC);
        check("addi_imm", 16'(bus_h.ImmSrc), 16'(2'b00));
        step("addi_exec",  L_I, 1'b0, 1'b1, C_EXI);
        step("addi_wb",    L_I, 1'b0, 1'b1, C_AWB);

        // sw with three wait cycles in MEMWR
        step("sw_fetch", L_SW, 1'b0, 1'b1, C_F1);
        step("sw_dec",   L_SW, 1'b0, 1'b1, C_DEC);
        check("sw_imm", 16'(bus_h.ImmSrc), 16'(2'b01));
        step("sw_adr",   L_SW, 1'b0, 1'b1, C_MADR);
        step("sw_wr_w1", L_SW, 1'b0, 1'b0, C_MWR);
        step("sw_wr_w2", L_SW, 1'b0, 1'b0, C_MWR);
        step("sw_wr_w3", L_SW, 1'b0, 1'b0, C_MWR);
        step("sw_wr",    L_SW, 1'b0, 1'b1, C_MWR);

        // reset while a store is stalled
        step("rst_fetch", L_SW, 1'b0, 1'b1, C_F1);
        step("rst_dec",   L_SW, 1'b0, 1'b1, C_DEC);
        step("rst_adr",   L_SW, 1'b0, 1'b1, C_MADR);
        step("rst_wr",    L_SW, 1'b0, 1'b0, C_MWR);
        rst = 1'b1;
        step("rst_abort", L_SW, 1'b0, 1'b0, C_F0);
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("rst_follow_h", 16'(ctrl_h), 16'(C_F1));
        check("rst_follow_c", 16'(ctrl_c), 16'(C_F1));

        // illegal opcode: halting and returning variants
        step("trap_dec", L_ILL, 1'b0, 1'b1, C_DEC);
        check("ill_imm", 16'(bus_h.ImmSrc), 16'(2'b00));
        step("trap",     L_ILL, 1'b0, 1'b1, C_TRAP);
        both = 1'b0;
        step("trap_hold", L_ILL, 1'b0, 1'b1, C_TRAP);
        check("trap_ret_c", 16'(ctrl_c), 16'(C_F1));
        for (int i = 0; i < 10; i++) begin
            step($sformatf("trap_hold%0d", i), L_ILL, 1'b0, 1'b1, C_TRAP);
        end

        rst = 1'b1;
        both = 1'b1;
        step("final_rst", L_R, 1'b0, 1'b0, C_F0);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
